// File: rtl/dial_lock_over_zero_if.sv
// ============================================================================
// dial_lock_over_zero_if : command/result bundle for the zero-crossing dial
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package dial_lock_over_zero_pkg;
  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;
endpackage

interface dial_lock_over_zero_if #(
  parameter int DATA_WIDTH = 32
);
  import dial_lock_over_zero_pkg::*;

  logic                  en;
  dir_t                  dir;
  logic [DATA_WIDTH-1:0] rot;
  logic [DATA_WIDTH-1:0] zeros;

  modport master (output en, output dir, output rot, input zeros);
  modport slave  (input en, input dir, input rot, output zeros);
endinterface

`default_nettype wire

// File: rtl/dial_lock_over_zero.sv
// ============================================================================
// dial_lock_over_zero : 100-position dial, counts every click that lands on 0
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dial_lock_over_zero
  import dial_lock_over_zero_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIAL_SIZE  = 100,
  parameter int START_POS  = 50
) (
  input  wire logic              clock,
  input  wire logic              reset,
  dial_lock_over_zero_if.slave   bus
);

  localparam int POS_W = $clog2(DIAL_SIZE);

  localparam logic [DATA_WIDTH-1:0] C_DIAL_D = DATA_WIDTH'(DIAL_SIZE);
  localparam logic [POS_W:0]        C_DIAL_P = (POS_W+1)'(DIAL_SIZE);

  logic [POS_W-1:0]      r_pos;
  logic [DATA_WIDTH-1:0] r_zeros;

  logic [DATA_WIDTH-1:0] w_q;
  logic [POS_W-1:0]      w_r;
  logic [POS_W:0]        w_sum;
  logic                  w_wrap_right;
  logic                  w_hit_left;
  logic [POS_W-1:0]      w_pos_right;
  logic [POS_W-1:0]      w_pos_left;
  logic [POS_W-1:0]      w_pos_next;
  logic [DATA_WIDTH-1:0] w_hits;

  // Constant divisor: maps to a multiply-by-reciprocal, single cycle.
  assign w_q = bus.rot / C_DIAL_D;
  assign w_r = POS_W'(bus.rot % C_DIAL_D);

  // r is always below DIAL_SIZE, so one extra bit over pos covers pos + r.
  assign w_sum        = {1'b0, r_pos} + {1'b0, w_r};
  assign w_wrap_right = (w_sum >= C_DIAL_P);
  assign w_pos_right  = w_wrap_right ? POS_W'(w_sum - C_DIAL_P) : w_sum[POS_W-1:0];

  // Leaving 0 does not count; reaching or passing 0 from above counts once.
  assign w_hit_left = (r_pos != '0) && (w_r >= r_pos);
  assign w_pos_left = (w_r > r_pos) ? POS_W'({1'b0, r_pos} + C_DIAL_P - {1'b0, w_r})
                                    : (r_pos - w_r);

  always_comb begin
    w_pos_next = w_pos_left;
    w_hits     = w_q + DATA_WIDTH'(w_hit_left);
    if (bus.dir == RIGHT) begin
      w_pos_next = w_pos_right;
      w_hits     = w_q + DATA_WIDTH'(w_wrap_right);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pos   <= POS_W'(START_POS);
      r_zeros <= '0;
    end else if (bus.en) begin
      r_pos   <= w_pos_next;
      r_zeros <= r_zeros + w_hits;
    end
  end

  assign bus.zeros = r_zeros;

endmodule

`default_nettype wire

// File: tb/tb_dial_lock_over_zero.sv
// ============================================================================
// tb_dial_lock_over_zero : directed self-checking bench for dial_lock_over_zero
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dial_lock_over_zero;
  import dial_lock_over_zero_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  dial_lock_over_zero_if #(.DATA_WIDTH(32)) bus ();

  dial_lock_over_zero #(
    .DATA_WIDTH (32),
    .DIAL_SIZE  (100),
    .START_POS  (50)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b0;
    bus.en = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic cmd(input dir_t d, input logic [31:0] n);
    bus.en  = 1'b1;
    bus.dir = d;
    bus.rot = n;
    @(negedge clock);
    bus.en  = 1'b0;
  endtask

  // Click-by-click reference: step one position at a time and count arrivals at 0.
  task automatic model_step(input int pos_in, input dir_t d, input int n,
                            output int pos_out, output int hits);
    int p;
    p    = pos_in;
    hits = 0;
    for (int k = 0; k < n; k++) begin
      if (d == RIGHT) p = (p == 99) ? 0 : p + 1;
      else            p = (p == 0) ? 99 : p - 1;
      if (p == 0) hits++;
    end
    pos_out = p;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.zeros !== 32'd0) begin
      errors++;
      $display("FAIL reset_zeros got %0d want 0", bus.zeros);
    end
    repeat (5) @(negedge clock);
    checks++;
    if (bus.zeros !== 32'd0) begin
      errors++;
      $display("FAIL idle_zeros got %0d want 0", bus.zeros);
    end
    checks++;
    if (dut.r_pos !== 7'd50) begin
      errors++;
      $display("FAIL idle_pos got %0d want 50", dut.r_pos);
    end
  endtask

  task automatic test_sequence();
    dir_t        ds [10] = '{LEFT, LEFT, RIGHT, LEFT, RIGHT, LEFT, LEFT, LEFT, RIGHT, LEFT};
    logic [31:0] ns [10] = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.en  = 1'b1;
      bus.dir = ds[i];
      bus.rot = ns[i];
      @(negedge clock);
    end
    bus.en = 1'b0;
    checks++;
    if (bus.zeros !== 32'd6) begin
      errors++;
      $display("FAIL seq_zeros got %0d want 6", bus.zeros);
    end
    checks++;
    if (dut.r_pos !== 7'd32) begin
      errors++;
      $display("FAIL seq_pos got %0d want 32", dut.r_pos);
    end
  endtask

  task automatic test_multi_turn();
    do_reset();
    cmd(RIGHT, 1000);
    checks++;
    if (bus.zeros !== 32'd10 || dut.r_pos !== 7'd50) begin
      errors++;
      $display("FAIL r1000 got zeros=%0d pos=%0d want zeros=10 pos=50", bus.zeros, dut.r_pos);
    end
    cmd(LEFT, 50);
    checks++;
    if (bus.zeros !== 32'd11 || dut.r_pos !== 7'd0) begin
      errors++;
      $display("FAIL l50_land got zeros=%0d pos=%0d want zeros=11 pos=0", bus.zeros, dut.r_pos);
    end
    cmd(LEFT, 5);
    checks++;
    if (bus.zeros !== 32'd11 || dut.r_pos !== 7'd95) begin
      errors++;
      $display("FAIL l5_leave got zeros=%0d pos=%0d want zeros=11 pos=95", bus.zeros, dut.r_pos);
    end
  endtask

  task automatic test_full_turns();
    do_reset();
    cmd(RIGHT, 50);
    checks++;
    if (bus.zeros !== 32'd1 || dut.r_pos !== 7'd0) begin
      errors++;
      $display("FAIL r50_land got zeros=%0d pos=%0d want zeros=1 pos=0", bus.zeros, dut.r_pos);
    end
    cmd(RIGHT, 100);
    checks++;
    if (bus.zeros !== 32'd2 || dut.r_pos !== 7'd0) begin
      errors++;
      $display("FAIL r100_turn got zeros=%0d pos=%0d want zeros=2 pos=0", bus.zeros, dut.r_pos);
    end
    cmd(RIGHT, 0);
    checks++;
    if (bus.zeros !== 32'd2 || dut.r_pos !== 7'd0) begin
      errors++;
      $display("FAIL r0_noop got zeros=%0d pos=%0d want zeros=2 pos=0", bus.zeros, dut.r_pos);
    end
    cmd(LEFT, 0);
    checks++;
    if (bus.zeros !== 32'd2 || dut.r_pos !== 7'd0) begin
      errors++;
      $display("FAIL l0_noop got zeros=%0d pos=%0d want zeros=2 pos=0", bus.zeros, dut.r_pos);
    end
    // 0xFFFFFFFF = 42949672*100 + 95; from 0 the 95 leftover clicks stop short of 0.
    cmd(RIGHT, 32'hFFFF_FFFF);
    checks++;
    if (bus.zeros !== 32'd42949674 || dut.r_pos !== 7'd95) begin
      errors++;
      $display("FAIL rmax got zeros=%0d pos=%0d want zeros=42949674 pos=95", bus.zeros, dut.r_pos);
    end
  endtask

  task automatic test_enable_toggle();
    int   mpos;
    int   mzeros;
    int   npos;
    int   h;
    int   n;
    dir_t d;
    do_reset();
    mpos   = 50;
    mzeros = 0;
    for (int i = 0; i < 24; i++) begin
      n = int'($urandom_range(0, 450));
      d = dir_t'($urandom_range(0, 1));
      bus.dir = d;
      bus.rot = 32'(n);
      bus.en  = (i % 2 == 0);
      @(negedge clock);
      if (i % 2 == 0) begin
        model_step(mpos, d, n, npos, h);
        mpos   = npos;
        mzeros = mzeros + h;
      end
      checks++;
      if (bus.zeros !== 32'(mzeros) || dut.r_pos !== 7'(mpos)) begin
        errors++;
        $display("FAIL toggle_%0d got zeros=%0d pos=%0d want zeros=%0d pos=%0d",
                 i, bus.zeros, dut.r_pos, mzeros, mpos);
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_back_to_back_reset();
    do_reset();
    bus.en  = 1'b1;
    bus.dir = RIGHT;
    bus.rot = 32'd10;
    @(negedge clock);
    bus.rot = 32'd90;
    @(negedge clock);
    bus.rot = 32'd100;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.zeros !== 32'd0 || dut.r_pos !== 7'd50) begin
      errors++;
      $display("FAIL async_reset got zeros=%0d pos=%0d want zeros=0 pos=50", bus.zeros, dut.r_pos);
    end
    @(negedge clock);
    bus.en = 1'b0;
    reset  = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.zeros !== 32'd0 || dut.r_pos !== 7'd50) begin
      errors++;
      $display("FAIL post_release got zeros=%0d pos=%0d want zeros=0 pos=50", bus.zeros, dut.r_pos);
    end
    cmd(LEFT, 50);
    checks++;
    if (bus.zeros !== 32'd1 || dut.r_pos !== 7'd0) begin
      errors++;
      $display("FAIL after_reset_l50 got zeros=%0d pos=%0d want zeros=1 pos=0", bus.zeros, dut.r_pos);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    bus.en  = 1'b0;
    bus.dir = LEFT;
    bus.rot = '0;
    test_reset();
    test_sequence();
    test_multi_turn();
    test_full_turns();
    test_enable_toggle();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
